// File: rtl/regfile_write_queue_pkg.sv
// Shared constants for the register-file write queue: register width, register
// count, register-index width and the default queue depth.
package regfile_write_queue_pkg;

    localparam int WORD_SIZE = 16;
    localparam int NUM_REGS  = 4;
    localparam int REG_IDX_W = 2;
    localparam int WQ_DEPTH  = 4;

endpackage

// File: rtl/regfile_wq_fwd.sv
// Youngest-match search over the valid queue entries for one read index.
// Walks oldest to youngest from the head so the last match found wins.
module regfile_wq_fwd
    import regfile_write_queue_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 4
) (
    input  logic [REG_IDX_W-1:0]     i_ent_reg  [DEPTH],
    input  logic [DATA_W-1:0]        i_ent_data [DEPTH],
    input  logic [$clog2(DEPTH)-1:0] i_head,
    input  logic [$clog2(DEPTH):0]   i_count,
    input  logic [REG_IDX_W-1:0]     i_rd_reg,
    output logic                     o_hit,
    output logic [DATA_W-1:0]        o_data
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    always_comb begin
        o_hit  = 1'b0;
        o_data = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if ((CNT_W'(k) < i_count) && (i_ent_reg[i_head + PTR_W'(k)] == i_rd_reg)) begin
                o_hit  = 1'b1;
                o_data = i_ent_data[i_head + PTR_W'(k)];
            end
        end
    end

endmodule

// File: rtl/regfile_write_queue.sv
// Two-producer in-order write queue in front of a single-write-port register
// file, with pending-write status and youngest-value forwarding for two readers.
module regfile_write_queue
    import regfile_write_queue_pkg::*;
#(
    parameter int WORD_SIZE = regfile_write_queue_pkg::WORD_SIZE,
    parameter int NUM_REGS  = regfile_write_queue_pkg::NUM_REGS,
    parameter int DEPTH     = regfile_write_queue_pkg::WQ_DEPTH
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     a_valid,
    input  logic [REG_IDX_W-1:0]     a_reg,
    input  logic [WORD_SIZE-1:0]     a_data,
    output logic                     a_ready,
    input  logic                     b_valid,
    input  logic [REG_IDX_W-1:0]     b_reg,
    input  logic [WORD_SIZE-1:0]     b_data,
    output logic                     b_ready,
    output logic                     rf_we,
    output logic [REG_IDX_W-1:0]     rf_waddr,
    output logic [WORD_SIZE-1:0]     rf_wdata,
    input  logic [REG_IDX_W-1:0]     rd1_reg,
    input  logic [REG_IDX_W-1:0]     rd2_reg,
    output logic                     fwd1_hit,
    output logic                     fwd2_hit,
    output logic [WORD_SIZE-1:0]     fwd1_data,
    output logic [WORD_SIZE-1:0]     fwd2_data,
    output logic [NUM_REGS-1:0]      pending,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [REG_IDX_W-1:0] r_reg  [DEPTH];
    logic [WORD_SIZE-1:0] r_data [DEPTH];
    logic [PTR_W-1:0]     r_head;
    logic [PTR_W-1:0]     r_tail;
    logic [CNT_W-1:0]     r_count;

    logic                 w_push_a;
    logic                 w_push_b;
    logic                 w_pop;
    logic [PTR_W-1:0]     w_b_slot;

    // Readiness looks only at the registered occupancy; a same-cycle pop never frees a slot.
    assign a_ready  = !reset && (r_count < CNT_W'(DEPTH));
    assign b_ready  = !reset && ((r_count < CNT_W'(DEPTH - 1)) ||
                                 ((r_count == CNT_W'(DEPTH - 1)) && !a_valid));

    assign w_push_a = a_valid && a_ready;
    assign w_push_b = b_valid && b_ready;
    assign w_pop    = (r_count != '0);
    assign w_b_slot = w_push_a ? (r_tail + PTR_W'(1)) : r_tail;

    assign rf_we    = w_pop;
    assign rf_waddr = r_reg[r_head];
    assign rf_wdata = r_data[r_head];
    assign count    = r_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_head  <= r_head + PTR_W'(w_pop);
            r_tail  <= r_tail + PTR_W'(w_push_a) + PTR_W'(w_push_b);
            r_count <= r_count + CNT_W'(w_push_a) + CNT_W'(w_push_b) - CNT_W'(w_pop);
        end
    end

    // Entry storage carries no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (w_push_a) begin
            r_reg[r_tail]  <= a_reg;
            r_data[r_tail] <= a_data;
        end
        if (w_push_b) begin
            r_reg[w_b_slot]  <= b_reg;
            r_data[w_b_slot] <= b_data;
        end
    end

    always_comb begin
        pending = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (CNT_W'(k) < r_count) begin
                pending[r_reg[r_head + PTR_W'(k)]] = 1'b1;
            end
        end
    end

    regfile_wq_fwd #(
        .DATA_W (WORD_SIZE),
        .DEPTH  (DEPTH)
    ) u_fwd1 (
        .i_ent_reg  (r_reg),
        .i_ent_data (r_data),
        .i_head     (r_head),
        .i_count    (r_count),
        .i_rd_reg   (rd1_reg),
        .o_hit      (fwd1_hit),
        .o_data     (fwd1_data)
    );

    regfile_wq_fwd #(
        .DATA_W (WORD_SIZE),
        .DEPTH  (DEPTH)
    ) u_fwd2 (
        .i_ent_reg  (r_reg),
        .i_ent_data (r_data),
        .i_head     (r_head),
        .i_count    (r_count),
        .i_rd_reg   (rd2_reg),
        .o_hit      (fwd2_hit),
        .o_data     (fwd2_data)
    );

endmodule
